reg_context_sequencer: RTL and testbench

// Sequences the 32x32 register bank for context switches: SAVE copies r1..r31 to data memory, RESTORE

---
 rtl/reg_context_sequencer_pkg.sv | 27 ++
 rtl/reg_context_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reg_context_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_context_sequencer_pkg.sv
// Shared definitions for the register-context sequencer: bank geometry,
// first saved index and the FSM state type.
package reg_context_sequencer_pkg;

    localparam int unsigned CTX_NUM_REGS   = 32;
    localparam int unsigned CTX_RADDR_W    = 5;
    localparam int unsigned CTX_DATA_W     = 32;
    localparam int unsigned CTX_MEM_ADDR_W = 10;

    // r0 is hardwired in the bank, so a context slot starts at r1
    localparam int unsigned CTX_FIRST_IDX  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE     = 3'd1,
        ST_REST_REQ = 3'd2,
        ST_REST_WR  = 3'd3,
        ST_DONE     = 3'd4,
        ST_ABORT    = 3'd5
    } ctx_state_e;

    // States that are walking the register index and may be cancelled
    function automatic logic ctx_in_transfer(input ctx_state_e s);
        return (s == ST_SAVE) || (s == ST_REST_REQ) || (s == ST_REST_WR);
    endfunction

endpackage

// File: rtl/reg_context_sequencer.sv
// Context save/restore sequencer for the 32x32 register bank.
// SAVE streams r1..r31 to memory at base+idx; RESTORE reads base+idx and
// writes it back into the bank one register per read. The core is stalled
// while busy is high.
module reg_context_sequencer
    import reg_context_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS   = CTX_NUM_REGS,
    parameter int unsigned RADDR_W    = CTX_RADDR_W,
    parameter int unsigned DATA_W     = CTX_DATA_W,
    parameter int unsigned MEM_ADDR_W = CTX_MEM_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_save,
    input  logic                  start_restore,
    input  logic                  abort,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [RADDR_W-1:0]    rf_addr,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  rf_we,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [RADDR_W-1:0] FIRST_IDX = RADDR_W'(CTX_FIRST_IDX);
    localparam logic [RADDR_W-1:0] LAST_IDX  = RADDR_W'(NUM_REGS - 1);

    ctx_state_e              state_q, state_d;
    logic [RADDR_W-1:0]      idx_q, idx_d;
    logic [MEM_ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;

    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic [RADDR_W-1:0]      rf_addr_q, rf_addr_d;
    logic                    rf_we_q, rf_we_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Next state, index, latched base and restore capture register
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            ST_IDLE: begin
                // save has priority when both starts arrive together
                if (start_save) begin
                    state_d = ST_SAVE;
                    base_d  = base_addr;
                    idx_d   = FIRST_IDX;
                end else if (start_restore) begin
                    state_d = ST_REST_REQ;
                    base_d  = base_addr;
                    idx_d   = FIRST_IDX;
                end
            end
            ST_SAVE: begin
                if (mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + RADDR_W'(1);
                    end
                end
            end
            ST_REST_REQ: begin
                if (mem_ack) begin
                    rf_wdata_d = mem_rdata;
                    state_d    = ST_REST_WR;
                end
            end
            ST_REST_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + RADDR_W'(1);
                    state_d = ST_REST_REQ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort replaces whatever successor was chosen above; a transfer
        // acked in this same cycle has already completed on the memory side.
        if (abort && ctx_in_transfer(state_q)) begin
            state_d = ST_ABORT;
        end
    end

    // Registered outputs decoded from the next state so they line up with it
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        aborted_d  = (state_d == ST_ABORT);
        mem_req_d  = (state_d == ST_SAVE) || (state_d == ST_REST_REQ);
        mem_we_d   = (state_d == ST_SAVE);
        mem_addr_d = mem_req_d ? (base_d + MEM_ADDR_W'(idx_d)) : '0;
        rf_we_d    = (state_d == ST_REST_WR);
        rf_addr_d  = ctx_in_transfer(state_d) ? idx_d : '0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= FIRST_IDX;
            base_q     <= '0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            rf_addr_q  <= rf_addr_d;
            rf_we_q    <= rf_we_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign rf_addr  = rf_addr_q;
    assign rf_we    = rf_we_q;
    assign rf_wdata = rf_wdata_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;

    // The bank read port is combinational on rf_addr, so save data passes
    // straight through; rf_addr is held until ack, which keeps it stable.
    assign mem_wdata = (state_q == ST_SAVE) ? rf_rdata : '0;

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Bench for reg_context_sequencer: register bank and data memory models,
// a per-cycle transfer scoreboard and directed scenarios.
module tb_reg_context_sequencer;

    typedef struct packed {
        logic [9:0]  addr;
        logic        we;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rfw_t;

    logic        clock = 1'b0;
    logic        reset, start_save, start_restore, abort;
    logic [9:0]  base_addr;
    logic        busy, done, aborted;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata, rf_wdata;
    logic        rf_we, mem_req, mem_we, mem_ack;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] rf  [32];
    logic [31:0] src [32];

    xfer_t exp_mem[$];
    rfw_t  exp_rf[$];

    int n_cmp = 0, n_bad = 0;
    int n_rfw = 0, n_xfer = 0, n_done = 0, n_abort = 0;
    bit after_abort = 1'b0;
    bit ack_tied = 1'b1;
    int wait_cnt = 0;

    always #5 clock = ~clock;

    assign rf_rdata  = rf[rf_addr];
    assign mem_ack   = ack_tied | (wait_cnt == 0);
    assign mem_rdata = (mem_ack && mem_req && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;

    reg_context_sequencer #(
        .NUM_REGS(32), .RADDR_W(5), .DATA_W(32), .MEM_ADDR_W(10)
    ) dut (
        .clock(clock), .reset(reset),
        .start_save(start_save), .start_restore(start_restore), .abort(abort),
        .base_addr(base_addr), .busy(busy), .done(done), .aborted(aborted),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Save: r1..r31 land at base+k (10-bit wrap) carrying the register value
    task automatic build_save(input logic [9:0] base);
        xfer_t e;
        exp_mem.delete();
        exp_rf.delete();
        for (int k = 1; k < 32; k++) begin
            e.addr = base + 10'(k);
            e.we   = 1'b1;
            e.data = src[k];
            exp_mem.push_back(e);
        end
    endtask

    // Restore: read base+k, then rK receives the memory image word a^0xFFFF
    task automatic build_restore(input logic [9:0] base);
        xfer_t e;
        rfw_t  r;
        exp_mem.delete();
        exp_rf.delete();
        for (int k = 1; k < 32; k++) begin
            e.addr = base + 10'(k);
            e.we   = 1'b0;
            e.data = '0;
            exp_mem.push_back(e);
            r.addr = 5'(k);
            r.data = 32'(e.addr) ^ 32'h0000_FFFF;
            exp_rf.push_back(r);
        end
    endtask

    // Memory, bank and ack-delay models
    task automatic env_loop();
        forever begin
            @(posedge clock);
            if (mem_req === 1'b1 && mem_ack === 1'b1 && mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            if (rf_we === 1'b1 && rf_addr != 5'd0) rf[rf_addr] <= rf_wdata;
            if (mem_req === 1'b1 && mem_ack === 1'b1) wait_cnt <= int'($urandom_range(0, 3));
            else if (mem_req === 1'b1 && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
        end
    endtask

    // Per-cycle compare against the expected transfer/write streams
    task automatic monitor();
        logic        ph = 1'b0;
        logic [9:0]  pa = '0;
        logic        pw = 1'b0;
        logic [31:0] pd = '0;
        xfer_t e;
        rfw_t  r;
        forever begin
            @(negedge clock);
            if (ph) begin
                chk("hold_req",   mem_req,   1);
                chk("hold_addr",  mem_addr,  pa);
                chk("hold_we",    mem_we,    pw);
                chk("hold_wdata", mem_wdata, pd);
            end
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                n_xfer++;
                chk("req_implies_busy", busy, 1);
                chk("xfer_expected", exp_mem.size() != 0, 1);
                if (exp_mem.size() != 0) begin
                    e = exp_mem.pop_front();
                    chk("xfer_addr", mem_addr, e.addr);
                    chk("xfer_we", mem_we, e.we);
                    if (e.we) chk("xfer_wdata", mem_wdata, e.data);
                end
            end
            if (rf_we === 1'b1) begin
                n_rfw++;
                chk("rf_write_expected", exp_rf.size() != 0, 1);
                if (exp_rf.size() != 0) begin
                    r = exp_rf.pop_front();
                    chk("rf_write_addr", rf_addr, r.addr);
                    chk("rf_write_data", rf_wdata, r.data);
                end
            end
            if (after_abort) begin
                chk("no_rf_we_after_abort", rf_we, 0);
                chk("no_req_after_abort", mem_req, 0);
            end
            if (done === 1'b1) n_done++;
            if (aborted === 1'b1) n_abort++;
            ph = (mem_req === 1'b1) && (mem_ack !== 1'b1);
            pa = mem_addr;
            pw = mem_we;
            pd = mem_wdata;
        end
    endtask

    task automatic kick(input bit s, input bit r, input logic [9:0] b);
        @(posedge clock); #1;
        start_save    = s;
        start_restore = r;
        base_addr     = b;
    endtask

    // cyc counts the cycle in which the start was driven as cycle 1
    task automatic run_until_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
            start_save    = 1'b0;
            start_restore = 1'b0;
        end
    endtask

    // Step until mem_req targets addr in the given direction; starts are dropped after one cycle
    task automatic wait_req(input logic [9:0] addr, input logic we, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (mem_req === 1'b1 && mem_we === we && mem_addr === addr) begin
                found = 1'b1;
                break;
            end
            @(posedge clock); #1;
            start_save    = 1'b0;
            start_restore = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        bit ok;
        int s_rfw, s_xfer, s_done, s_abort;

        reset = 1'b0; start_save = 1'b0; start_restore = 1'b0; abort = 1'b0; base_addr = '0;
        for (int a = 0; a < 1024; a++) mem[a] <= 32'(a) ^ 32'h0000_FFFF;
        for (int k = 0; k < 32; k++) begin
            src[k] = 32'(k * 3);
            rf[k] <= 32'(k * 3);
        end

        fork
            env_loop();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0); chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0); chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clock); #1 reset = 1'b1;

        // Abort while idle is ignored
        @(posedge clock); #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        chk("idle_abort_no_pulse", aborted, 0);
        chk("idle_abort_busy", busy, 0);

        // Save, ack tied high, base 0x100, rK = 3K
        s_rfw = n_rfw; s_xfer = n_xfer;
        build_save(10'h100);
        kick(1, 0, 10'h100);
        run_until_done(100, cyc, ok);
        chk("save_done_cycle", cyc, 33);
        @(negedge clock);
        chk("save_idle_after_done", busy, 0);
        chk("save_queue_drained", exp_mem.size(), 0);
        chk("save_xfer_count", n_xfer - s_xfer, 31);
        chk("save_no_rf_we", n_rfw - s_rfw, 0);
        chk("save_mem_101", mem[10'h101], 32'd3);
        chk("save_mem_11F", mem[10'h11F], 32'd93);
        chk("save_r0_not_saved", mem[10'h100], 32'h0000_FEFF);
        chk("save_no_write_past_r31", mem[10'h120], 32'h0000_FEDF);

        // Restore, ack tied high, base 0x3F0 wraps through 0x000
        for (int k = 0; k < 32; k++) rf[k] <= '0;
        build_restore(10'h3F0);
        kick(0, 1, 10'h3F0);
        run_until_done(150, cyc, ok);
        chk("restore_done_cycle", cyc, 64);
        @(posedge clock); #1;
        chk("restore_queue_drained", exp_mem.size(), 0);
        chk("restore_rf_drained", exp_rf.size(), 0);
        chk("restore_r1", rf[1], 32'h0000_FC0E);
        chk("restore_r16_wrap", rf[16], 32'h0000_FFFF);
        chk("restore_r31", rf[31], 32'h0000_FFF0);
        chk("restore_r0_untouched", rf[0], 32'h0);

        // Save with random 0..3 cycle ack delay, base 0x200
        for (int k = 1; k < 32; k++) begin
            src[k] = $urandom;
            rf[k] <= src[k];
        end
        ack_tied = 1'b0;
        s_xfer = n_xfer;
        build_save(10'h200);
        kick(1, 0, 10'h200);
        run_until_done(400, cyc, ok);
        chk("rand_save_done_seen", ok, 1);
        @(posedge clock); #1;
        ack_tied = 1'b1;
        chk("rand_save_drained", exp_mem.size(), 0);
        chk("rand_save_xfer_count", n_xfer - s_xfer, 31);
        chk("rand_save_mem_21F", mem[10'h21F], src[31]);

        // Both starts together -> save; re-pulses mid-save are ignored
        s_rfw = n_rfw; s_xfer = n_xfer; s_done = n_done;
        build_save(10'h050);
        kick(1, 1, 10'h050);
        repeat (10) begin
            @(posedge clock); #1;
            start_save = 1'b0; start_restore = 1'b0;
        end
        start_save = 1'b1; start_restore = 1'b1; base_addr = 10'h2AA;
        @(posedge clock); #1;
        start_save = 1'b0; start_restore = 1'b0;
        run_until_done(100, cyc, ok);
        chk("both_starts_done_seen", ok, 1);
        repeat (4) begin
            @(negedge clock);
            chk("no_queued_start", busy, 0);
        end
        chk("both_starts_drained", exp_mem.size(), 0);
        chk("both_starts_xfers", n_xfer - s_xfer, 31);
        chk("both_starts_no_restore", n_rfw - s_rfw, 0);
        chk("both_starts_one_done", n_done - s_done, 1);
        chk("both_starts_mem_051", mem[10'h051], src[1]);
        chk("rebase_not_used", mem[10'h2AB], 32'h0000_FD54);

        // Abort at idx 7 of a restore from base 0x000
        for (int k = 0; k < 32; k++) rf[k] <= '0;
        s_rfw = n_rfw; s_done = n_done; s_abort = n_abort;
        build_restore(10'h000);
        kick(0, 1, 10'h000);
        wait_req(10'h007, 1'b0, ok);
        chk("abort_point_reached", ok, 1);
        #1 abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        after_abort = 1'b1;
        @(negedge clock);
        chk("abort_pulse", aborted, 1);
        chk("abort_busy_still", busy, 1);
        @(negedge clock);
        chk("abort_pulse_width", aborted, 0);
        chk("abort_busy_cleared", busy, 0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        after_abort = 1'b0;
        chk("abort_rf_writes_le7", (n_rfw - s_rfw) <= 7, 1);
        chk("abort_no_done", n_done - s_done, 0);
        chk("abort_one_pulse", n_abort - s_abort, 1);
        chk("abort_r6_restored", rf[6], 32'h0000_FFF9);
        chk("abort_r8_untouched", rf[8], 32'h0);

        // Reset at idx 12 of a save, then a fresh save from idx 1
        for (int k = 1; k < 32; k++) begin
            src[k] = 32'(k * 3);
            rf[k] <= src[k];
        end
        build_save(10'h100);
        kick(1, 0, 10'h100);
        wait_req(10'h10C, 1'b1, ok);
        chk("reset_point_reached", ok, 1);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", busy, 0);        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_we", mem_we, 0);    chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_rf_we", rf_we, 0);      chk("midrst_rf_addr", rf_addr, 0);
        chk("midrst_done", done, 0);        chk("midrst_aborted", aborted, 0);
        chk("midrst_mem_wdata", mem_wdata, 0); chk("midrst_rf_wdata", rf_wdata, 0);
        build_save(10'h100);
        kick(1, 0, 10'h100);
        run_until_done(100, cyc, ok);
        chk("post_reset_save_cycle", cyc, 33);
        @(negedge clock);
        chk("post_reset_save_drained", exp_mem.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
